nios_core_cpu_mult_pipe: RTL

// - Parametrised, pipelined integer multiplier for the Nios core M-stage datapath: full-product successor to the

---
 rtl/nios_core_cpu_mult_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/nios_core_cpu_mult_pipe.sv
// nios_core_cpu_mult_pipe
// Three-stage pipelined integer multiplier for the M-stage datapath.
//   S1: operand/mode/tag register
//   S2: full 2*DATA_W product from 16x16 partial products
//   S3: result-half select and output register
// Accept-to-out_valid latency is fixed at 3 cycles; valid/ready handshake with
// whole-pipe stall on backpressure, and flush kills all in-flight operations.
// Optional accumulator: define NIOS_MULT_PIPE_ACC_EN to add acc_en/acc_clr ports
// and a 2*DATA_W accumulator updated by ops that reach S3 with acc_en set.
module nios_core_cpu_mult_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
`ifdef NIOS_MULT_PIPE_ACC_EN
  input  logic              acc_en,
  input  logic              acc_clr,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int PW = 2 * DATA_W;   // full product width
  localparam int NL = PW / 16;      // 16-bit limbs per extended operand

  // Pipeline advances whenever the output slot is empty or being consumed
  logic adv;

  // S1 registers
  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [1:0]        s1_mode;
  logic [TAG_W-1:0]  s1_tag;

  // S2 registers
  logic              s2_valid;
  logic [PW-1:0]     s2_prod;
  logic [1:0]        s2_mode;
  logic [TAG_W-1:0]  s2_tag;

  // Product datapath
  logic [PW-1:0]     a_ext;
  logic [PW-1:0]     b_ext;
  logic [PW-1:0]     prod;

  // S3 source and selected half
  logic [PW-1:0]     res_src;
  logic [DATA_W-1:0] res_sel;

`ifdef NIOS_MULT_PIPE_ACC_EN
  logic              s1_acc_en;
  logic              s2_acc_en;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     acc_sum;
`endif

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Sign-extend operands to 2*DATA_W and sum the 16x16 partial products.
  // Extending all the way to 2*DATA_W lets one unsigned limb array cover every
  // mode: the product modulo 2^(2*DATA_W) is exact, and limb pairs whose
  // weight lands at or above 2*DATA_W are skipped.
  always_comb begin
    logic [31:0] pp;
    logic [PW-1:0] pp_w;
    a_ext = {{DATA_W{s1_mode[1] & s1_a[DATA_W-1]}}, s1_a};
    b_ext = {{DATA_W{(s1_mode == 2'b11) & s1_b[DATA_W-1]}}, s1_b};
    prod  = '0;
    pp    = '0;
    pp_w  = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      for (int unsigned j = 0; j < NL - i; j++) begin
        pp   = a_ext[16*i +: 16] * b_ext[16*j +: 16];
        pp_w = PW'(pp);
        prod = prod + (pp_w << (16 * (i + j)));
      end
    end
  end

  // Result source (product or updated accumulator) and half select
  always_comb begin
`ifdef NIOS_MULT_PIPE_ACC_EN
    acc_sum = acc + s2_prod;
    res_src = s2_acc_en ? acc_sum : s2_prod;
`else
    res_src = s2_prod;
`endif
    res_sel = (s2_mode == 2'b00) ? res_src[DATA_W-1:0] : res_src[PW-1:DATA_W];
  end

  // Stage valid bits: reset/flush clear everything, otherwise shift on adv
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  // S1/S2 data registers: shift on adv, no reset needed (qualified by valids)
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_a    <= in_a;
      s1_b    <= in_b;
      s1_mode <= in_mode;
      s1_tag  <= in_tag;
      s2_prod <= prod;
      s2_mode <= s1_mode;
      s2_tag  <= s1_tag;
`ifdef NIOS_MULT_PIPE_ACC_EN
      s1_acc_en <= acc_en;
      s2_acc_en <= s1_acc_en;
`endif
    end
  end

  // Output data/tag: cleared on reset, held while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_tag  <= '0;
    end else if (adv) begin
      out_data <= res_sel;
      out_tag  <= s2_tag;
    end
  end

`ifdef NIOS_MULT_PIPE_ACC_EN
  // Accumulator: clear wins over update; a flushed op never updates it
  always_ff @(posedge clk) begin
    if (reset || acc_clr) begin
      acc <= '0;
    end else if (adv && s2_valid && s2_acc_en && !flush) begin
      acc <= acc_sum;
    end
  end
`endif

endmodule
